// File: rtl/clk_en_pkg.sv
// Shared constants, types and helpers for the clock-enable generator.
package clk_en_pkg;

    // Default counter/divisor width and reset divisor.
    localparam int CW_DEF      = 26;
    localparam int DIV_RST_DEF = 2;

    typedef logic [CW_DEF-1:0] div_t;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: counts enabled edges, pulses tick on wrap and
// toggles sq. The divisor register is written whenever load is asserted; the
// parent only asserts load at a legal commit point (wrap, div==0 or sync).
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sync,
    input  logic          load,
    input  logic [CW-1:0] load_div,
    output logic          tick,
    output logic          sq,
    output logic          wrap,
    output logic          div_zero
);

    localparam logic [CW:0] ONE = (CW+1)'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;

    // Wrap compare is done one bit wider so div-1 cannot underflow.
    assign div_zero = (div == '0);
    assign wrap     = en && !div_zero && ({1'b0, cnt} >= ({1'b0, div} - ONE));

    // Counter, divisor and registered tick/sq; sync overrides wrap and en.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            div  <= CW'(DIV_RST);
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            if (load)
                div <= load_div;
            if (sync) begin
                cnt  <= '0;
                tick <= 1'b0;
                sq   <= 1'b0;
            end else if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
            end else if (en && !div_zero) begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator. Owns the single pending
// divisor slot and the cfg_ready handshake; each channel is a clk_en_chan.
// Optional free-running cycle counter port: CLK_EN_GEN_FREERUN_EN.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = CW_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sync,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ch_w(NCH)-1:0]   cfg_ch,
    input  logic [CW-1:0]          cfg_div,
`ifdef CLK_EN_GEN_FREERUN_EN
    output logic [31:0]            free_cnt,
`endif
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sq
);

    localparam int CHW = ch_w(NCH);

    logic           pend_vld;
    logic [CHW-1:0] pend_ch;
    logic [CW-1:0]  pend_div;
    logic           commit_d;
    logic [NCH-1:0] load;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] div_zero;
    logic           commit;
    logic           xfer;
    logic           ch_ok;

    assign xfer   = cfg_valid && cfg_ready;
    assign ch_ok  = int'(cfg_ch) < NCH;
    assign commit = |load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // A pending update lands at the target's wrap, at once if it is idle, or on sync.
        assign load[i] = pend_vld && (pend_ch == CHW'(i)) && (sync || wrap[i] || div_zero[i]);

        clk_en_chan #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (en),
            .sync     (sync),
            .load     (load[i]),
            .load_div (pend_div),
            .tick     (tick[i]),
            .sq       (sq[i]),
            .wrap     (wrap[i]),
            .div_zero (div_zero[i])
        );
    end

    // Pending slot and ready: ready drops on an in-range transfer, returns the edge after commit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_div  <= '0;
            commit_d  <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            commit_d <= commit;
            if (commit)
                pend_vld <= 1'b0;
            if (commit_d) begin
                cfg_ready <= 1'b1;
            end else if (xfer && ch_ok) begin
                pend_vld  <= 1'b1;
                pend_ch   <= cfg_ch;
                pend_div  <= cfg_div;
                cfg_ready <= 1'b0;
            end
        end
    end

`ifdef CLK_EN_GEN_FREERUN_EN
    // Free-running cycle counter, independent of en and sync.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            free_cnt <= '0;
        else
            free_cnt <= free_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: a behavioural model predicts tick/sq/cfg_ready
// for every edge, pushes the prediction, and it is popped and compared after the edge.
module tb_clk_en_gen;
    localparam int NCH = 3;
    localparam int CW  = 8;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sync;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_div;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
`ifdef CLK_EN_GEN_FREERUN_EN
    logic [31:0]   free_cnt;
`endif

    clk_en_gen #(.NCH(NCH), .CW(CW), .DIV_RST(2)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLK_EN_GEN_FREERUN_EN
        .free_cnt  (free_cnt),
`endif
        .tick      (tick),
        .sq        (sq)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic           rdy;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int             m_cnt[NCH];
    int             m_div[NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;
    bit             m_pv, m_rdy, m_cd;
    int             m_pch, m_pdiv;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_div[i] = 2;
        end
        m_tick = '0; m_sq = '0;
        m_pv = 0; m_rdy = 1; m_cd = 0; m_pch = 0; m_pdiv = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit com[NCH];
        bit any_com = 0;
        for (int i = 0; i < NCH; i++) begin
            com[i] = m_pv && (m_pch == i) &&
                     (sync || m_div[i] == 0 || (en && m_cnt[i] + 1 >= m_div[i]));
            any_com |= com[i];
        end
        for (int i = 0; i < NCH; i++) begin
            if (sync) begin
                m_cnt[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
            end else if (en && m_div[i] != 0) begin
                if (m_cnt[i] + 1 >= m_div[i]) begin
                    m_cnt[i] = 0; m_tick[i] = 1; m_sq[i] = ~m_sq[i];
                end else begin
                    m_cnt[i]++; m_tick[i] = 0;
                end
            end else begin
                m_tick[i] = 0;
            end
            if (com[i]) m_div[i] = m_pdiv;
        end
        if (any_com) m_pv = 0;
        if (m_cd) m_rdy = 1;
        else if (cfg_valid && m_rdy && int'(cfg_ch) < NCH) begin
            m_pv = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_rdy = 0;
        end
        m_cd = any_com;
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        sbq.push_back({m_tick, m_sq, m_rdy});
        @(posedge clk_in);
        #1;
        e = sbq.pop_front();
        chk("tick", 32'(tick), 32'(e.tick));
        chk("sq", 32'(sq), 32'(e.sq));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_write(input int ch, input int dv);
        int n = 0;
        while (!m_rdy && n < 300) begin
            step();
            n++;
        end
        if (!m_rdy) chk("cfg_wait_timeout", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CW'(dv);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        #12;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_sq", 32'(sq), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        en    = 1'b1;

        // Reset divisor 2: ticks every other edge
        run(8);
        // ch1 -> 5, committed at its next wrap
        cfg_write(1, 5);
        run(14);
        // ch2 -> 1 (tick held), then 0 (frozen), then a write that commits next edge
        cfg_write(2, 1);
        run(6);
        cfg_write(2, 0);
        run(5);
        cfg_write(2, 4);
        run(8);
        // ch0=3, ch1=7, sync mid-period
        cfg_write(0, 3);
        cfg_write(1, 7);
        run(9);
        sync = 1'b1; step(); sync = 1'b0;
        run(10);
        // en low for 10 cycles mid-count, then resume
        run(2);
        en = 1'b0; run(10); en = 1'b1;
        run(10);
        // Out-of-range channel: discarded, ready stays high
        cfg_write(3, 50);
        run(4);
        // Async reset with an update pending
        cfg_write(1, 9);
        chk("pending_before_rst", 32'(cfg_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_sq", 32'(sq), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd1);
        #2 rst_n = 1'b1;
        run(8);
        // Long old period, pending update forced in by sync
        cfg_write(0, 100);
        run(3);
        cfg_write(0, 3);
        run(2);
        sync = 1'b1; step(); sync = 1'b0;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel, runtime-programmable clock-enable generator that replaces fixed power-of-two divider taps with per-channel integer divide ratios. All channels run from one clock. Each channel produces a single-cycle `tick` enable and a toggling `sq` wave. Consumers (CPU/IO stepping, VGA pixel enable, 7-seg scan, blink) use `tick` as a clock enable instead of deriving clocks from counter bits. Divisors change at runtime through a valid/ready port, and changes are glitch-free.

## Interface
- `NCH`, 4: number of channels (≥1)
- `CW`, 26: counter/divisor width in bits
- `DIV_RST`, 2: divisor loaded into every channel at reset

- `clk_in`  input  1  sole clock
- `rst_n`  input  1  asynchronous, active-low reset
- `en`  input  1  global run; 0 freezes all counters
- `sync`  input  1  phase-align all channels (restart)
- `cfg_valid`  input  1  divisor update request
- `cfg_ready`  output  1  update port can accept
- `cfg_ch`  input  max(1,$clog2(NCH))  target channel
- `cfg_div`  input  CW  new divisor N; 0 = channel disabled
- `tick`  output  NCH  one-cycle pulse per channel, period N
- `sq`  output  NCH  toggles on each tick, period 2N
- `free_cnt`  output  32  free-running cycle counter (only with `CLK_EN_GEN_FREERUN_EN`)

## Operation
- Per-channel state: `cnt[CW]`, `div[CW]`. Outputs `tick` and `sq` are registered.
- Rising edge with `en`=1 and `div`≠0:
  - if `cnt` ≥ `div`−1: `cnt`←0, `tick`←1, `sq`←~`sq` (wrap)
  - else: `cnt`←`cnt`+1, `tick`←0
- Compare is done in CW+1 bits, so `div`−1 never underflows.
- `div`=1: `tick` is held high and `sq` toggles every cycle.
- `div`=0: `cnt` is held at 0, `tick`=0, `sq` holds its value.
- `en`=0: `cnt` and `sq` hold and `tick`=0. The cfg port still operates.
- Config handshake:
  - A transfer occurs on an edge where `cfg_valid`&`cfg_ready`=1.
  - On transfer, `cfg_ch`/`cfg_div` are latched into a single pending slot and `cfg_ready`←0.
  - Commit to the target channel happens:
    - at that channel's next wrap; the wrap still uses the old divisor, and `cnt`←0, `div`←pending;
    - immediately on the next edge if the channel's current `div`=0;
    - immediately on `sync`.
  - The edge after commit sets `cfg_ready`←1.
  - `cfg_ch` ≥ `NCH`: the transfer is accepted and discarded, and `cfg_ready` stays 1.
- `sync`=1 takes priority over wrap and `en`:
  - every `cnt`←0, `tick`←0, `sq`←0;
  - any pending update commits in the same edge.
- Simultaneous transfer and commit cannot occur, because `cfg_ready`=0 while a slot is pending.

## Timing
- Reset values: `cnt`=0, `div`=`DIV_RST`, `tick`=0, `sq`=0, `cfg_ready`=1, pending slot empty, `free_cnt`=0.
- Reset acts asynchronously mid-operation and discards any pending update.
- With divisor N from reset or `sync`, `tick` is first high in the cycle after the N-th enabled edge, then every N enabled edges.
- Update latency: the new period starts counting from the commit edge, and the first tick at the new rate appears N_new enabled edges later. `cfg_ready` returns to 1 one cycle after commit.
- Worst-case wait from transfer to commit: `div`_old enabled edges. The wait is unbounded while `en`=0, unless the channel's `div`=0 or `sync` asserts.

## Configuration
- `CLK_EN_GEN_FREERUN_EN` defined: port `free_cnt[31:0]` exists.
  - It increments every edge regardless of `en`.
  - It is cleared by reset only, not by `sync`, and wraps at 2^32.
- Macro undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package `clk_en_pkg`: `CW` default constant and `typedef logic [CW-1:0] div_t`.
- Sub-module `clk_en_chan`: one channel.
  - Inputs: `clk_in`, `rst_n`, `en`, `sync`, `load`, `load_div`.
  - Outputs: `tick`, `sq`, `wrap`, `div_zero`.
- The top level instantiates `NCH` copies in a generate loop and owns the pending slot and the `cfg_ready` logic.

## Test plan
- Reset, `en`=1, `DIV_RST`=2 → `tick[0]` high on cycles 2,4,6…; `sq[0]` toggles every 2 cycles; `cfg_ready`=1.
- Write ch1 `div`=5 during an old period of 2 → `cfg_ready` drops, commit occurs at ch1 wrap, ticks then follow every 5 cycles, and `cfg_ready` is high one cycle after commit.
- `div`=1 on ch2 → `tick[2]` held high and `sq[2]` toggles every cycle. `div`=0 → `tick[2]`=0, `sq` frozen, and a later write commits on the next edge.
- Channels at `div` 3 and 7, assert `sync` mid-period → all `tick`/`sq`=0, and the next ticks land on enabled edges 3 and 7 after `sync`.
- `en`=0 for 10 cycles mid-count → no ticks; resuming continues from the held `cnt`.
- Write with `cfg_ch`=`NCH` → no divisor changes and `cfg_ready` stays 1. Assert `rst_n`=0 with an update pending → slot cleared and all outputs at reset values.
